// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM states,
// address field positions and array geometry.
package cache_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2,
    WRITE  = 2'd3
  } cache_state_t;

  // Word address layout: tag | index | word offset.
  localparam int TAG_MSB = 9;
  localparam int TAG_LSB = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 2;
  localparam int OFF_MSB = 1;
  localparam int OFF_LSB = 0;

  // Array geometry.
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 32;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Sequencing controller for the direct-mapped cache data array. Decodes CPU
// loads/stores against the array hit flag, drives one array command at a
// time, runs refill (block read) and write-through handshakes with data
// memory, and stalls the CPU until each access completes.
//
// Handshakes: cpu_rd_req/cpu_wr_req are held (with cpu_addr stable) until a
// cycle in which stall is low; that cycle's rising edge completes the access.
// mem_rd_req/mem_wr_req are held until mem_ready pulses for one cycle, and
// mem_ready is only acted on in MISS and WRITE.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              hit_miss,
  output logic              stall,
  output logic              rd_en_cm,
  output logic              wr_en_cm,
  output logic              mem_to_cache_en,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  cache_state_t state;
  cache_state_t state_next;
  logic         prev_refill;

  logic stall_c;
  logic rd_en_c;
  logic wr_en_c;
  logic fill_c;
  logic mem_rd_c;
  logic mem_wr_c;
  logic hit_inc;
  logic miss_inc;

  // State register; reset returns to IDLE without waiting for memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember a REFILL cycle so the retried load is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_refill <= 1'b0;
    end else begin
      prev_refill <= (state == REFILL);
    end
  end

  // Next-state and command decode.
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    rd_en_c    = 1'b0;
    wr_en_c    = 1'b0;
    fill_c     = 1'b0;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr_req) begin
          // Write-through, no-write-allocate: update the array only on a hit.
          wr_en_c    = hit_miss;
          stall_c    = 1'b1;
          state_next = WRITE;
        end else if (cpu_rd_req) begin
          if (hit_miss) begin
            rd_en_c = 1'b1;
            hit_inc = !prev_refill;
          end else begin
            stall_c    = 1'b1;
            miss_inc   = 1'b1;
            state_next = MISS;
          end
        end
      end
      MISS: begin
        mem_rd_c = 1'b1;
        stall_c  = 1'b1;
        if (mem_ready) state_next = REFILL;
      end
      REFILL: begin
        fill_c     = 1'b1;
        stall_c    = 1'b1;
        state_next = IDLE;
      end
      WRITE: begin
        mem_wr_c = 1'b1;
        stall_c  = !mem_ready;
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, including the IDLE decode.
  assign stall           = stall_c  & rst_n;
  assign rd_en_cm        = rd_en_c  & rst_n;
  assign wr_en_cm        = wr_en_c  & rst_n;
  assign mem_to_cache_en = fill_c   & rst_n;
  assign mem_rd_req      = mem_rd_c & rst_n;
  assign mem_wr_req      = mem_wr_c & rst_n;

  sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

  // Array commands are mutually exclusive, as are memory requests.
  a_cmd_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({rd_en_cm, wr_en_cm, mem_to_cache_en}));
  a_mem_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({mem_rd_req, mem_wr_req}));

  // A stalled CPU keeps its address steady into the next cycle.
  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (stall && (cpu_rd_req || cpu_wr_req)) |=> $stable(cpu_addr));

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller. Each transaction's expected
// output waveform is built up front from the access rules (hit, miss with
// latency L, store with latency L) into exp_q and then compared cycle by
// cycle; hit/miss statistics are tracked as saturating integers.
module tb_cache_controller;

  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Expected output vector bit order: {stall, rd_en, wr_en, fill, mem_rd, mem_wr}
  localparam logic [5:0] V_HIT   = 6'b010000;
  localparam logic [5:0] V_STALL = 6'b100000;
  localparam logic [5:0] V_MRD   = 6'b100010;
  localparam logic [5:0] V_FILL  = 6'b100100;
  localparam logic [5:0] V_IDLE  = 6'b000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              hit_miss;
  logic              stall;
  logic              rd_en_cm;
  logic              wr_en_cm;
  logic              mem_to_cache_en;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  logic [5:0] obs_vec;
  logic [5:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cache_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_rd_req      (cpu_rd_req),
    .cpu_wr_req      (cpu_wr_req),
    .cpu_addr        (cpu_addr),
    .hit_miss        (hit_miss),
    .stall           (stall),
    .rd_en_cm        (rd_en_cm),
    .wr_en_cm        (wr_en_cm),
    .mem_to_cache_en (mem_to_cache_en),
    .mem_rd_req      (mem_rd_req),
    .mem_wr_req      (mem_wr_req),
    .mem_ready       (mem_ready),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  // Clock and output bundle.
  always #5 clk = ~clk;
  assign obs_vec = {stall, rd_en_cm, wr_en_cm, mem_to_cache_en, mem_rd_req, mem_wr_req};

  // Runaway guard.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  32'(hit_cnt),  32'(exp_hits));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_misses));
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Play exp_q against the DUT; inputs are set just after a rising edge,
  // outputs compared at the falling edge.
  task automatic run_read(input logic [ADDR_W-1:0] addr, input bit hit, input int lat);
    exp_q.delete();
    if (hit) begin
      exp_q.push_back(V_HIT);
      exp_hits = sat_inc(exp_hits);
    end else begin
      exp_q.push_back(V_STALL);
      for (int i = 0; i < lat; i++) exp_q.push_back(V_MRD);
      exp_q.push_back(V_FILL);
      exp_q.push_back(V_HIT);   // retried load, not counted as a hit
      exp_misses = sat_inc(exp_misses);
    end
    cpu_rd_req = 1'b1;
    cpu_wr_req = 1'b0;
    cpu_addr   = addr;
    for (int k = 0; exp_q.size() > 0; k++) begin
      if (hit) begin
        hit_miss  = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
      end else if (k == 0) begin
        hit_miss  = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
      end else if (k <= lat) begin
        hit_miss  = 1'($urandom_range(0, 1));
        mem_ready = (k == lat);
      end else if (k == lat + 1) begin
        hit_miss  = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
      end else begin
        hit_miss  = 1'b1;   // line is now present
        mem_ready = 1'b0;
      end
      @(negedge clk);
      check(hit ? "rd_hit_out" : "rd_miss_out", 32'(obs_vec), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    cpu_rd_req = 1'b0;
    mem_ready  = 1'b0;
    check_counters("rd");
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] addr, input bit hit, input int lat, input bit also_rd);
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, hit, 3'b000});
    for (int i = 1; i <= lat; i++) exp_q.push_back({(i != lat), 4'b0000, 1'b1});
    cpu_wr_req = 1'b1;
    cpu_rd_req = also_rd;
    cpu_addr   = addr;
    for (int k = 0; exp_q.size() > 0; k++) begin
      if (k == 0) begin
        hit_miss  = hit;
        mem_ready = 1'($urandom_range(0, 1));
      end else begin
        hit_miss  = 1'($urandom_range(0, 1));
        mem_ready = (k == lat);
      end
      @(negedge clk);
      check(also_rd ? "wr_prio_out" : "wr_out", 32'(obs_vec), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    mem_ready  = 1'b0;
    check_counters("wr");
  endtask

  task automatic run_idle();
    cpu_rd_req = 1'b0;
    cpu_wr_req = 1'b0;
    cpu_addr   = ADDR_W'($urandom_range(0, 1023));
    hit_miss   = 1'($urandom_range(0, 1));
    mem_ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_out", 32'(obs_vec), 32'(V_IDLE));
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  initial begin
    // Reset with a request pending: everything must read zero.
    rst_n      = 1'b0;
    cpu_rd_req = 1'b1;
    cpu_wr_req = 1'b0;
    cpu_addr   = 10'h114;
    hit_miss   = 1'b1;
    mem_ready  = 1'b0;
    #2;
    check("reset_out", 32'(obs_vec), 32'(V_IDLE));
    check_counters("reset");
    cpu_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_read(10'h114, 1'b1, 0);
    run_read(10'h2A0, 1'b0, 3);
    run_write(10'h114, 1'b1, 2, 1'b0);
    run_write(10'h3FF, 1'b0, 1, 1'b0);
    run_write(10'h055, 1'b1, 3, 1'b1);
    run_write(10'h056, 1'b0, 2, 1'b1);
    run_idle();
    run_read(10'h114, 1'b1, 0);

    // Reset two cycles into MISS: outputs drop at once, counters clear.
    cpu_rd_req = 1'b1;
    cpu_addr   = 10'h2A0;
    hit_miss   = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    check("rst_miss_req", 32'(obs_vec), 32'(V_STALL));
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_miss_mrd", 32'(obs_vec), 32'(V_MRD));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    check("rst_mid_out", 32'(obs_vec), 32'(V_IDLE));
    check_counters("rst_mid");
    @(negedge clk);
    check("rst_hold_out", 32'(obs_vec), 32'(V_IDLE));
    cpu_rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_idle();
    check_counters("rst_rel");
    run_read(10'h114, 1'b1, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: run_read(ADDR_W'($urandom_range(0, 1023)), 1'b1, 0);
        1: run_read(ADDR_W'($urandom_range(0, 1023)), 1'b0, int'($urandom_range(1, 5)));
        2: run_write(ADDR_W'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        default: run_idle();
      endcase
    end

    // Saturation: stream back-to-back hits up to 0xFFFE, then three more.
    cpu_rd_req = 1'b1;
    cpu_wr_req = 1'b0;
    hit_miss   = 1'b1;
    cpu_addr   = 10'h114;
    repeat (CNT_MAX - 1 - exp_hits) @(posedge clk);
    #1;
    exp_hits = CNT_MAX - 1;
    cpu_rd_req = 1'b0;
    check_counters("sat_pre");
    for (int n = 0; n < 3; n++) run_read(10'h114, 1'b1, 0);
    check("sat_hold", 32'(hit_cnt), 32'(CNT_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
